// File: rtl/uart_tx_scheduler.sv
// Shares one 16-bit serial transmitter between N_REQ requesters, timing frames and gaps in clocks.
// Optional build macro UART_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module uart_tx_scheduler #(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = 5,
   parameter int FRAME_BITS   = 19,
   parameter int GAP_CLKS     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [16*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      gnt,
   output logic                  busy,
   output logic [15:0]           tx_data,
   output logic                  tx_wr
);

   localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
   localparam int CNT_MAX    = (FRAME_CLKS > GAP_CLKS) ? FRAME_CLKS : GAP_CLKS;
   localparam int CNT_W      = $clog2(CNT_MAX + 1);
   localparam int PTR_W      = $clog2(N_REQ);

   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CLKS - 1);
   localparam logic [N_REQ-1:0] GNT_ONE    = N_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               busy_q, busy_d;
   logic [15:0]        tx_data_q, tx_data_d;
   logic               tx_wr_q, tx_wr_d;

   logic               found_s;
   logic [PTR_W-1:0]   win_s;
   logic [15:0]        win_data_s;

`ifdef UART_SCHED_FIXED_PRIO_EN
   // Fixed priority: scan from the top so the lowest set index is the last one written.
   always_comb begin
      found_s    = 1'b0;
      win_s      = '0;
      win_data_s = 16'h0000;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            found_s    = 1'b1;
            win_s      = PTR_W'(i);
            win_data_s = req_data[16*i +: 16];
         end else begin
            found_s    = found_s;
         end
      end
   end
`else
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   int                 idx_s;

   // Round-robin: first set request at or above rr_ptr, wrapping at N_REQ.
   always_comb begin
      found_s    = 1'b0;
      win_s      = '0;
      win_data_s = 16'h0000;
      idx_s      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx_s = (int'(rr_ptr_q) + i) % N_REQ;
         if (!found_s && req[idx_s]) begin
            found_s    = 1'b1;
            win_s      = PTR_W'(idx_s);
            win_data_s = req_data[16*idx_s +: 16];
         end else begin
            found_s    = found_s;
         end
      end
   end
`endif

   // Next-state and registered-output logic of the frame scheduler.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ack_d     = '0;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = tx_wr_q;
`ifndef UART_SCHED_FIXED_PRIO_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d   = ST_SEND;
               tx_data_d = win_data_s;
               tx_wr_d   = 1'b1;
               gnt_d     = GNT_ONE << win_s;
               busy_d    = 1'b1;
               cnt_d     = '0;
`ifndef UART_SCHED_FIXED_PRIO_EN
               rr_ptr_d  = (win_s == PTR_W'(N_REQ - 1)) ? '0 : win_s + PTR_W'(1);
`endif
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (cnt_q == FRAME_LAST) begin
               state_d = ST_GAP;
               tx_wr_d = 1'b0;
               cnt_d   = '0;
               ack_d   = gnt_q;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            // gnt stays with the owner until the gap has returned the transmitter to idle
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            tx_wr_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ack_q     <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         tx_data_q <= 16'h0000;
         tx_wr_q   <= 1'b0;
`ifndef UART_SCHED_FIXED_PRIO_EN
         rr_ptr_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
`ifndef UART_SCHED_FIXED_PRIO_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

   assign ack     = ack_q;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign tx_data = tx_data_q;
   assign tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected {gnt, word} pushed at request time, popped at frame start.
module tb_uart_tx_scheduler;

   localparam int N_REQ        = 4;
   localparam int CLKS_PER_BIT = 5;
   localparam int FRAME_BITS   = 19;
   localparam int GAP_CLKS     = 2;
   localparam int FRAME_CLKS   = 95;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N_REQ-1:0]    req;
   logic [16*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]    ack;
   logic [N_REQ-1:0]    gnt;
   logic                busy;
   logic [15:0]         tx_data;
   logic                tx_wr;

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .N_REQ(N_REQ), .CLKS_PER_BIT(CLKS_PER_BIT), .FRAME_BITS(FRAME_BITS), .GAP_CLKS(GAP_CLKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .ack(ack), .gnt(gnt), .busy(busy), .tx_data(tx_data), .tx_wr(tx_wr)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [19:0] exp_q[$];
   int          ack_cnt[N_REQ];
   logic [3:0]  drop_mask;

   bit          mon_en = 1'b0;
   bit          abort_mode = 1'b0;
   bit          prev_wr = 1'b0;
   bit          in_gap = 1'b0;
   int          len = 0;
   int          gap_cnt = 0;
   logic [3:0]  cur_gnt = 4'h0;
   logic [15:0] cur_data = 16'h0000;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [15:0] d);
      exp_q.push_back({g, d});
   endtask

   task automatic set_data(input int i, input logic [15:0] d);
      req_data[16*i +: 16] = d;
   endtask

   task automatic clear_acks();
      for (int i = 0; i < N_REQ; i++) ack_cnt[i] = 0;
   endtask

   // One clock per step; requesters in drop_mask release req on seeing their ack.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (ack[i]) begin
               ack_cnt[i]++;
               if (drop_mask[i]) req[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic wait_tx(input int max_c);
      int c = 0;
      while (!tx_wr && c < max_c) begin
         tick(1);
         c++;
      end
      check_eq("wait_tx_timeout", 32'(tx_wr), 32'd1);
   endtask

   task automatic wait_quiet(input int max_c);
      int c = 0;
      while ((busy || req != 4'h0) && c < max_c) begin
         tick(1);
         c++;
      end
      check_eq("quiet_timeout", {30'd0, busy, (req != 4'h0)}, 32'd0);
      tick(3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'h0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // Frame monitor: pops the scoreboard at frame start, checks hold, length, ack and gap.
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         if (tx_wr) begin
            if (!prev_wr) begin
               check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  {cur_gnt, cur_data} = exp_q.pop_front();
               end
               check_eq("start_gnt", 32'(gnt), 32'(cur_gnt));
               check_eq("start_data", 32'(tx_data), 32'(cur_data));
               len = 1;
            end else begin
               len++;
               check_eq("send_data_hold", 32'(tx_data), 32'(cur_data));
               check_eq("send_gnt_hold", 32'(gnt), 32'(cur_gnt));
            end
            check_eq("send_busy", 32'(busy), 32'd1);
            check_eq("send_ack", 32'(ack), 32'd0);
         end else if (prev_wr) begin
            if (abort_mode) begin
               check_eq("abort_ack", 32'(ack), 32'd0);
               check_eq("abort_gnt", 32'(gnt), 32'd0);
               check_eq("abort_busy", 32'(busy), 32'd0);
            end else begin
               check_eq("frame_len", 32'(len), 32'(FRAME_CLKS));
               check_eq("ack_owner", 32'(ack), 32'(cur_gnt));
               check_eq("gap_gnt", 32'(gnt), 32'(cur_gnt));
               check_eq("gap_busy", 32'(busy), 32'd1);
               in_gap  = 1'b1;
               gap_cnt = 1;
            end
         end else begin
            check_eq("ack_quiet", 32'(ack), 32'd0);
            if (busy) begin
               gap_cnt++;
               check_eq("gap_gnt_hold", 32'(gnt), 32'(cur_gnt));
            end else begin
               if (in_gap) begin
                  check_eq("gap_len", 32'(gap_cnt), 32'(GAP_CLKS));
                  in_gap = 1'b0;
               end
               check_eq("idle_gnt", 32'(gnt), 32'd0);
            end
         end
         prev_wr = tx_wr;
      end
   end

   initial begin
      int tot;
      int c;
      rst_n     = 1'b0;
      req       = 4'h0;
      req_data  = '0;
      drop_mask = 4'hF;
      clear_acks();
      tick(2);
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'd0);
      check_eq("rst_tx_wr", 32'(tx_wr), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick(1);

      // single request, one-edge latency
      set_data(0, 16'hA5C3);
      push_exp(4'b0001, 16'hA5C3);
      req = 4'b0001;
      tick(1);
      check_eq("t1_latency_wr", 32'(tx_wr), 32'd1);
      check_eq("t1_gnt", 32'(gnt), 32'h1);
      check_eq("t1_busy", 32'(busy), 32'd1);
      wait_quiet(300);
      check_eq("t1_ack0", 32'(ack_cnt[0]), 32'd1);
      check_eq("t1_busy_after", 32'(busy), 32'd0);

      // all four requesting from a fresh pointer
      do_reset();
      clear_acks();
      for (int i = 0; i < N_REQ; i++) begin
         set_data(i, 16'h1111 * 16'(i + 1));
         push_exp(4'b0001 << i, 16'h1111 * 16'(i + 1));
      end
      req = 4'b1111;
      wait_quiet(1000);
      for (int i = 0; i < N_REQ; i++) check_eq("t2_ack_once", 32'(ack_cnt[i]), 32'd1);

      // data change and req drop mid-frame
      clear_acks();
      set_data(0, 16'h5A5A);
      push_exp(4'b0001, 16'h5A5A);
      req = 4'b0001;
      wait_tx(10);
      tick(10);
      set_data(0, 16'h0000);
      req[0] = 1'b0;
      wait_quiet(300);
      check_eq("t3_ack0", 32'(ack_cnt[0]), 32'd1);

      // reset in the middle of a frame
      clear_acks();
      set_data(0, 16'h1234);
      push_exp(4'b0001, 16'h1234);
      abort_mode = 1'b1;
      req = 4'b0001;
      wait_tx(10);
      tick(40);
      rst_n = 1'b0;
      req   = 4'h0;
      tick(1);
      check_eq("t4_wr", 32'(tx_wr), 32'd0);
      check_eq("t4_gnt", 32'(gnt), 32'd0);
      check_eq("t4_busy", 32'(busy), 32'd0);
      check_eq("t4_ack", 32'(ack), 32'd0);
      rst_n = 1'b1;
      tick(2);
      abort_mode = 1'b0;
      check_eq("t4_no_ack", 32'(ack_cnt[0]), 32'd0);
      set_data(3, 16'hBEEF);
      push_exp(4'b1000, 16'hBEEF);
      req = 4'b1000;
      tick(1);
      check_eq("t4_restart_wr", 32'(tx_wr), 32'd1);
      wait_quiet(300);
      check_eq("t4_ack3", 32'(ack_cnt[3]), 32'd1);

      // req0 and req2 held continuously for four frames
      do_reset();
      clear_acks();
      drop_mask = 4'h0;
      set_data(0, 16'h0F0F);
      set_data(2, 16'h2F2F);
`ifdef UART_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) push_exp(4'b0001, 16'h0F0F);
`else
      for (int i = 0; i < 2; i++) begin
         push_exp(4'b0001, 16'h0F0F);
         push_exp(4'b0100, 16'h2F2F);
      end
`endif
      req = 4'b0101;
      tot = 0;
      c   = 0;
      while (tot < 4 && c < 1000) begin
         tick(1);
         c++;
         tot = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
      end
      req       = 4'h0;
      drop_mask = 4'hF;
      check_eq("t5_frames", 32'(tot), 32'd4);
      wait_quiet(300);
`ifdef UART_SCHED_FIXED_PRIO_EN
      check_eq("t5_ack0", 32'(ack_cnt[0]), 32'd4);
      check_eq("t5_ack2", 32'(ack_cnt[2]), 32'd0);
`else
      check_eq("t5_ack0", 32'(ack_cnt[0]), 32'd2);
      check_eq("t5_ack2", 32'(ack_cnt[2]), 32'd2);
`endif

      // req1 arrives in the first gap cycle of requester 0's frame
      clear_acks();
      set_data(0, 16'h6060);
      set_data(1, 16'h6161);
      push_exp(4'b0001, 16'h6060);
      push_exp(4'b0010, 16'h6161);
      req = 4'b0001;
      c   = 0;
      while (ack_cnt[0] == 0 && c < 300) begin
         tick(1);
         c++;
      end
      check_eq("t6_ack0_seen", 32'(ack[0]), 32'd1);
      req[1] = 1'b1;
      wait_quiet(400);
      check_eq("t6_ack0", 32'(ack_cnt[0]), 32'd1);
      check_eq("t6_ack1", 32'(ack_cnt[1]), 32'd1);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
